// File: rtl/logic_pod_pkg.sv
// Shared definitions for the logic-pod DRAM write arbiter: default bus widths,
// FSM state encoding and small helpers used by the top and the arbiter.
package logic_pod_pkg;

  localparam int unsigned POD_ADDR_W  = 29;
  localparam int unsigned POD_DATA_W  = 256;
  localparam int unsigned POD_NUM     = 2;
  localparam int unsigned POD_CNT_W   = 32;
  localparam int unsigned POD_TO_DFLT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } pod_state_e;

  // Index of the pod selected by a one-hot two-pod grant vector.
  function automatic logic pod_idx(input logic [1:0] onehot);
    return onehot[1];
  endfunction

  // One-hot vector for a pod index.
  function automatic logic [1:0] pod_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/logic_pod_rr_arbiter.sv
// Two-way round-robin grant: the pod granted last drops to lowest priority,
// pod 0 wins ties out of reset. A masked pod is never eligible.
module logic_pod_rr_arbiter
  import logic_pod_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic [1:0] ack,
  output logic [1:0] grant
);

  logic       r_prio_pod1;
  logic [1:0] w_elig;

  // Combinational pick among eligible requesters.
  always_comb begin
    w_elig = req & ~mask;
    grant  = 2'b00;
    if (r_prio_pod1 && w_elig[1]) begin
      grant = pod_onehot(1'b1);
    end else if (w_elig[0]) begin
      grant = pod_onehot(1'b0);
    end else if (w_elig[1]) begin
      grant = pod_onehot(1'b1);
    end
  end

  // Priority moves away from whichever pod just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_pod1 <= 1'b0;
    end else if (ack[0]) begin
      r_prio_pod1 <= 1'b1;
    end else if (ack[1]) begin
      r_prio_pod1 <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_pod_ram_arbiter.sv
// Arbitrates two logic pods onto a single DRAM write port: one write in flight,
// registered address/data/strobe, per-pod completion pulse and write counters.
module logic_pod_ram_arbiter
  import logic_pod_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = POD_ADDR_W,
  parameter int unsigned DATA_WIDTH     = POD_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = POD_TO_DFLT
) (
  input  logic                  clk_ram,
  input  logic                  rst_n,
  input  logic                  ram_ready,
  input  logic [1:0]            pod_req,
  input  logic [ADDR_WIDTH-1:0] pod_addr [1:0],
  input  logic [DATA_WIDTH-1:0] pod_data [1:0],
  output logic [1:0]            pod_ack,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic                  ram_wr_done,
  output logic                  timeout_err,
  output logic [31:0]           wr_count [1:0]
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;

  pod_state_e            r_state;
  pod_state_e            w_state_nxt;

  logic [1:0]            w_grant;
  logic                  w_go;
  logic                  w_gnt_pod;
  logic                  w_to_hit;

  logic                  w_wr_en_nxt;
  logic [1:0]            w_ack_nxt;
  logic [1:0]            w_cnt_inc;
  logic                  w_to_set;
  logic [TO_W-1:0]       w_to_cnt_nxt;

  logic                  r_wr_en;
  logic [1:0]            r_pod_ack;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_gnt_pod;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_to_err;
  logic [POD_CNT_W-1:0]  r_wr_count [1:0];

  // Reset asserts immediately, releases two clk_ram edges later.
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // The pod acked this cycle is masked so the other pod gets the next slot.
  logic_pod_rr_arbiter u_rr (
    .clk   (clk_ram),
    .rst_n (w_rst_n),
    .req   (pod_req),
    .mask  (r_pod_ack),
    .ack   (w_ack_nxt),
    .grant (w_grant)
  );

  assign w_go      = ram_ready && (w_grant != 2'b00);
  assign w_gnt_pod = pod_idx(w_grant);
  assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_ram or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (ram_wr_done || w_to_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; a done seen on the same edge as
  // the timeout limit counts as a successful write.
  always_comb begin
    w_wr_en_nxt  = 1'b0;
    w_ack_nxt    = 2'b00;
    w_cnt_inc    = 2'b00;
    w_to_set     = 1'b0;
    w_to_cnt_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        w_wr_en_nxt = w_go;
      end
      ST_WAIT_DONE: begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        if (ram_wr_done) begin
          w_ack_nxt[r_gnt_pod] = 1'b1;
          w_cnt_inc[r_gnt_pod] = 1'b1;
        end else if (w_to_hit) begin
          w_ack_nxt[r_gnt_pod] = 1'b1;
          w_to_set             = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Address/data are captured only at grant, so they hold through the ack.
  always_ff @(posedge clk_ram or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_en       <= 1'b0;
      r_pod_ack     <= 2'b00;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_gnt_pod     <= 1'b0;
      r_to_cnt      <= '0;
      r_to_err      <= 1'b0;
      r_wr_count[0] <= '0;
      r_wr_count[1] <= '0;
    end else begin
      r_wr_en   <= w_wr_en_nxt;
      r_pod_ack <= w_ack_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      if (w_wr_en_nxt) begin
        r_wr_addr <= pod_addr[w_gnt_pod];
        r_wr_data <= pod_data[w_gnt_pod];
        r_gnt_pod <= w_gnt_pod;
      end
      if (w_to_set) begin
        r_to_err <= 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (w_cnt_inc[i]) begin
          r_wr_count[i] <= r_wr_count[i] + POD_CNT_W'(1);
        end
      end
    end
  end

  assign ram_wr_en   = r_wr_en;
  assign pod_ack     = r_pod_ack;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign timeout_err = r_to_err;
  assign wr_count[0] = r_wr_count[0];
  assign wr_count[1] = r_wr_count[1];

endmodule

// File: tb/tb_logic_pod_ram_arbiter.sv
// Scoreboard bench for logic_pod_ram_arbiter: pods push expected writes when
// they raise a request; each pod_ack pops and checks the held DRAM bus.
module tb_logic_pod_ram_arbiter;

  localparam int unsigned AW = 29;
  localparam int unsigned DW = 256;
  localparam int unsigned TO = 16;

  logic          clk_ram = 1'b0;
  logic          rst_n;
  logic          ram_ready;
  logic          ram_wr_done;
  logic [1:0]    pod_req;
  logic [AW-1:0] pod_addr [1:0];
  logic [DW-1:0] pod_data [1:0];
  logic [1:0]    pod_ack;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          timeout_err;
  logic [31:0]   wr_count [1:0];

  logic_pod_ram_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_ram     (clk_ram),
    .rst_n       (rst_n),
    .ram_ready   (ram_ready),
    .pod_req     (pod_req),
    .pod_addr    (pod_addr),
    .pod_data    (pod_data),
    .pod_ack     (pod_ack),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_done (ram_wr_done),
    .timeout_err (timeout_err),
    .wr_count    (wr_count)
  );

  always #5 clk_ram = ~clk_ram;

  typedef struct packed {
    logic          to;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         sb0[$];
  wr_t         sb1[$];
  wr_t         mon_e;
  int          ord_q[$];
  int          ack_cyc_q[$];
  int unsigned pend [2];
  logic [31:0] exp_cnt [2];
  logic        exp_to;
  logic        to_seen;
  logic        prev_wren;
  int          last_pod;
  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned n_wren;
  int unsigned n_ack;
  int unsigned cyc;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rnd_d();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic issue(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.to = exp_to;
    e.a  = a;
    e.d  = d;
    pod_addr[p] = a;
    pod_data[p] = d;
    pod_req[p]  = 1'b1;
    if (p == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  // Pod agents and scoreboard: sample outputs on the falling edge.
  always @(negedge clk_ram) begin
    cyc++;
    if (ram_wr_en) begin
      n_wren++;
      chk("wren_single_cycle", DW'(prev_wren), DW'(1'b0));
    end
    prev_wren = ram_wr_en;
    for (int p = 0; p < 2; p++) begin
      if (pod_ack[p]) begin
        n_ack++;
        ack_cyc_q.push_back(int'(cyc));
        chk("ack_expected", DW'((p == 0) ? (sb0.size() != 0) : (sb1.size() != 0)), DW'(1'b1));
        if ((p == 0 && sb0.size() != 0) || (p == 1 && sb1.size() != 0)) begin
          mon_e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("ack_addr", DW'(ram_wr_addr), DW'(mon_e.a));
          chk("ack_data", ram_wr_data, mon_e.d);
          if (!mon_e.to) exp_cnt[p] = exp_cnt[p] + 32'd1;
          else to_seen = 1'b1;
          chk("wr_count", DW'(wr_count[p]), DW'(exp_cnt[p]));
          chk("timeout_err", DW'(timeout_err), DW'(to_seen));
        end
        if (ord_q.size() != 0) chk("grant_order", DW'(p), DW'(ord_q.pop_front()));
        last_pod = p;
        if (pend[p] != 0) begin
          issue(p, AW'($urandom), rnd_d());
          pend[p]--;
        end else begin
          pod_req[p] = 1'b0;
        end
      end else if (!pod_req[p] && pend[p] != 0) begin
        issue(p, AW'($urandom), rnd_d());
        pend[p]--;
      end
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0 || pend[0] != 0 || pend[1] != 0) && k < budget) begin
      @(negedge clk_ram);
      k++;
    end
    chk(tag, DW'(sb0.size() == 0 && sb1.size() == 0 && pend[0] == 0 && pend[1] == 0), DW'(1'b1));
    @(negedge clk_ram);
  endtask

  task automatic wait_wren(input string tag, input int budget);
    int k;
    k = 0;
    while (!ram_wr_en && k < budget) begin
      @(negedge clk_ram);
      k++;
    end
    chk(tag, DW'(ram_wr_en), DW'(1'b1));
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_wr_en"}, DW'(ram_wr_en), '0);
    chk({pfx, "_ack"}, DW'(pod_ack), '0);
    chk({pfx, "_addr"}, DW'(ram_wr_addr), '0);
    chk({pfx, "_data"}, ram_wr_data, '0);
    chk({pfx, "_timeout_err"}, DW'(timeout_err), '0);
    chk({pfx, "_cnt0"}, DW'(wr_count[0]), '0);
    chk({pfx, "_cnt1"}, DW'(wr_count[1]), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          stable;
    int            k;
    int unsigned   n0;
    int            first;

    n_chk = 0; n_pass = 0; n_wren = 0; n_ack = 0; cyc = 0;
    exp_cnt[0] = '0; exp_cnt[1] = '0; exp_to = 1'b0; to_seen = 1'b0;
    prev_wren = 1'b0; last_pod = 1; pend[0] = 0; pend[1] = 0;
    rst_n = 1'b0; ram_ready = 1'b0; ram_wr_done = 1'b1; pod_req = 2'b00;
    pod_addr[0] = '0; pod_addr[1] = '0; pod_data[0] = '0; pod_data[1] = '0;

    // Reset values
    repeat (3) @(negedge clk_ram);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk_ram);
    ram_ready = 1'b1;
    @(negedge clk_ram);

    // Single write latency from pod 0
    d = {32{8'hA5}};
    issue(0, AW'(32'h100), d);
    @(negedge clk_ram);
    chk("lat_wren_n1", DW'(ram_wr_en), DW'(1'b1));
    chk("lat_addr", DW'(ram_wr_addr), DW'(32'h100));
    chk("lat_data", ram_wr_data, d);
    @(negedge clk_ram);
    chk("lat_wren_n2", DW'(ram_wr_en), DW'(1'b0));
    chk("lat_ack_n2", DW'(pod_ack), DW'(2'b00));
    @(negedge clk_ram);
    chk("lat_ack_n3", DW'(pod_ack), DW'(2'b01));
    chk("lat_cnt0", DW'(wr_count[0]), DW'(32'd1));
    wait_idle("lat_drain", 20);

    // Both pods back-to-back: strict alternation at one write per 3 cycles
    @(posedge clk_ram);
    first = 1 - last_pod;
    for (int i = 0; i < 8; i++) ord_q.push_back((first + i) % 2);
    ack_cyc_q.delete();
    pend[0] = 4;
    pend[1] = 4;
    wait_idle("rr_drain", 100);
    chk("rr_acks", DW'(ack_cyc_q.size()), DW'(8));
    if (ack_cyc_q.size() == 8) chk("rr_throughput", DW'(ack_cyc_q[7] - ack_cyc_q[0]), DW'(21));
    chk("rr_cnt0", DW'(wr_count[0]), DW'(32'd5));
    chk("rr_cnt1", DW'(wr_count[1]), DW'(32'd4));

    // Done delayed: bus holds, single strobe, ack one cycle after done
    ram_wr_done = 1'b0;
    n0 = n_wren;
    a = AW'($urandom);
    d = rnd_d();
    issue(1, a, d);
    wait_wren("slow_wren", 10);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk_ram);
      if (ram_wr_addr !== a || ram_wr_data !== d || ram_wr_en || pod_ack != 2'b00) stable = 1'b0;
    end
    ram_wr_done = 1'b1;
    @(negedge clk_ram);
    chk("slow_ack", DW'(pod_ack), DW'(2'b10));
    chk("slow_stable", DW'(stable), DW'(1'b1));
    chk("slow_one_strobe", DW'(n_wren - n0), DW'(1));
    wait_idle("slow_drain", 10);

    // Done never comes: abort after TO wait cycles
    ram_wr_done = 1'b0;
    exp_to = 1'b1;
    issue(0, AW'($urandom), rnd_d());
    exp_to = 1'b0;
    wait_wren("to_wren", 10);
    k = 0;
    while (!pod_ack[0] && k < 40) begin
      @(negedge clk_ram);
      k++;
    end
    chk("to_latency", DW'(k), DW'(TO + 1));
    chk("to_err_set", DW'(timeout_err), DW'(1'b1));
    chk("to_cnt_held", DW'(wr_count[0]), DW'(32'd5));
    wait_idle("to_drain", 10);
    ram_wr_done = 1'b1;
    issue(0, AW'($urandom), rnd_d());
    wait_idle("to_after", 20);
    chk("to_err_sticky", DW'(timeout_err), DW'(1'b1));
    chk("to_cnt_after", DW'(wr_count[0]), DW'(32'd6));

    // ram_ready gating
    ram_ready = 1'b0;
    n0 = n_wren;
    issue(1, AW'($urandom), rnd_d());
    repeat (6) @(negedge clk_ram);
    chk("noready_wren", DW'(n_wren - n0), '0);
    ram_ready = 1'b1;
    wait_idle("noready_drain", 20);
    ram_wr_done = 1'b0;
    issue(0, AW'($urandom), rnd_d());
    wait_wren("drop_wren", 10);
    @(negedge clk_ram);
    ram_ready = 1'b0;
    issue(1, AW'($urandom), rnd_d());
    repeat (3) @(negedge clk_ram);
    ram_wr_done = 1'b1;
    k = 0;
    while (sb0.size() != 0 && k < 20) begin
      @(negedge clk_ram);
      k++;
    end
    chk("drop_completes", DW'(sb0.size()), '0);
    n0 = n_wren;
    repeat (6) @(negedge clk_ram);
    chk("drop_no_grant", DW'(n_wren - n0), '0);
    chk("drop_pod1_pending", DW'(sb1.size()), DW'(1));
    ram_ready = 1'b1;
    wait_idle("drop_drain", 20);

    // Reset during WAIT_DONE: async clear, no ack, pod 0 first afterwards
    issue(0, AW'($urandom), rnd_d());
    wait_idle("pre_rst", 20);
    ram_wr_done = 1'b0;
    issue(1, AW'($urandom), rnd_d());
    wait_wren("rst_wren", 10);
    repeat (3) @(negedge clk_ram);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_cnt[0] = '0;
    exp_cnt[1] = '0;
    to_seen = 1'b0;
    n0 = n_ack;
    issue(0, AW'($urandom), rnd_d());
    ord_q.push_back(0);
    ord_q.push_back(1);
    ram_wr_done = 1'b1;
    repeat (4) @(negedge clk_ram);
    chk("rst_no_ack", DW'(n_ack - n0), '0);
    rst_n = 1'b1;
    wait_idle("rst_drain", 40);
    chk("rst_order_done", DW'(ord_q.size()), '0);
    chk("rst_cnt0", DW'(wr_count[0]), DW'(32'd1));
    chk("rst_cnt1", DW'(wr_count[1]), DW'(32'd1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
